// File: rtl/i2c_target_rx.sv
// Write-only I2C target: matches a 7-bit address, ACKs and captures up to 3 data bytes, pulses done on STOP.
// Bus event latency SYNC_STAGES+1 clk (SYNC_STAGES+4 with I2C_TARGET_GLITCH_FILTER_EN defined).
// No backpressure: byte_valid/done are strobes that the consumer must take on the cycle they appear.
module i2c_target_rx #(
  parameter int MAX_BYTES   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] addr,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe_n,
  output logic [7:0] rx_data0,
  output logic [7:0] rx_data1,
  output logic [7:0] rx_data2,
  output logic [1:0] rx_count,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_f, sda_f;   // clean bus levels seen by the protocol logic
  logic scl_q, sda_q;   // one-cycle-old copies for edge detection
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       full;     // 8 bits shifted in since the last byte boundary
  logic [1:0] idx;

  logic shift_en, bits_clr, byte_store, addr_acked, idx_inc, drive_ack, finish;

  // Bus idles high, so the synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  // A level only propagates after three consecutive equal samples; shorter pulses vanish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
      if (scl_hist == 3'b000) scl_f <= 1'b0;
      else if (scl_hist == 3'b111) scl_f <= 1'b1;
      if (sda_hist == 3'b000) sda_f <= 1'b0;
      else if (sda_hist == 3'b111) sda_f <= 1'b1;
    end
  end
`else
  assign scl_f = scl_sync[SYNC_STAGES-1];
  assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

  // Previous-sample register for SCL/SDA edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  =  scl_f & ~scl_q;
  assign scl_fall  = ~scl_f &  scl_q;
  assign start_det =  scl_f &  scl_q &  sda_q & ~sda_f;
  assign stop_det  =  scl_f &  scl_q & ~sda_q &  sda_f;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: STOP beats everything, then (repeated) START, then the byte/ACK sequencing.
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        ADDR:     if (full && scl_fall)
                    state_nxt = (shift[7:1] == addr && !shift[0]) ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall) state_nxt = DATA;
        DATA:     if (full && scl_fall)
                    state_nxt = (int'(idx) < MAX_BYTES) ? DATA_ACK : WAIT_STOP;
        DATA_ACK: if (scl_fall) state_nxt = DATA;
        default:  ;
      endcase
    end
  end

  // Datapath controls decoded from the current/next state pair.
  always_comb begin
    shift_en   = (state == ADDR || state == DATA) && scl_rise;
    bits_clr   = start_det || ((state == ADDR_ACK || state == DATA_ACK) && scl_fall);
    byte_store = (state == DATA) && (state_nxt == DATA_ACK);
    addr_acked = (state == ADDR_ACK) && (state_nxt == DATA);
    idx_inc    = (state == DATA_ACK) && (state_nxt == DATA);
    drive_ack  = (state_nxt == ADDR_ACK) || (state_nxt == DATA_ACK);
    finish     = stop_det && busy;
  end

  // Shift register, byte index, captured bytes and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift      <= '0;
      bit_cnt    <= '0;
      full       <= 1'b0;
      idx        <= '0;
      sda_oe_n   <= 1'b1;
      rx_data0   <= '0;
      rx_data1   <= '0;
      rx_data2   <= '0;
      rx_count   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      done       <= 1'b0;
      sda_oe_n   <= ~drive_ack;

      if (bits_clr) begin
        bit_cnt <= '0;
        full    <= 1'b0;
      end else if (shift_en) begin
        shift   <= {shift[6:0], sda_f};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) full <= 1'b1;
      end

      if (start_det || addr_acked) idx <= '0;
      else if (idx_inc)            idx <= idx + 2'd1;

      if (byte_store) begin
        case (idx)
          2'd0:    rx_data0 <= shift;
          2'd1:    rx_data1 <= shift;
          2'd2:    rx_data2 <= shift;
          default: ;
        endcase
        byte_valid <= 1'b1;
        byte_data  <= shift;
      end

      if (finish) begin
        rx_count <= idx;
        done     <= 1'b1;
      end

      if (stop_det || start_det) busy <= 1'b0;
      else if (addr_acked)       busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master on a wired-AND SDA, transaction-level expected model.
// Directed test-plan transactions followed by randomized ones; all waits are fixed clock counts.
// The target never stalls the bus, so no backpressure is exercised.
module tb_i2c_target_rx;
  localparam int Q = 6;  // quarter SCL period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [6:0] tgt;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe_n;
  logic [7:0] rx_data0, rx_data1, rx_data2, byte_data;
  logic [1:0] rx_count;
  logic       byte_valid, busy, done;

  assign sda_bus = m_sda & sda_oe_n;

  i2c_target_rx dut (
    .clk(clk), .reset_n(reset_n), .addr(tgt), .scl(m_scl), .sda_in(sda_bus),
    .sda_oe_n(sda_oe_n), .rx_data0(rx_data0), .rx_data1(rx_data1), .rx_data2(rx_data2),
    .rx_count(rx_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  // Expected model state
  logic [7:0] exp_q[$];
  int         exp_done = 0;
  logic [7:0] m_rx[3];
  logic [1:0] m_cnt;
  bit         quiet = 1'b0;
  logic [7:0] tx_d[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare of the DUT against the model
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (byte_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL byte_valid_unexpected: got byte %0h expected no strobe", byte_data);
          end else begin
            e = exp_q.pop_front();
            chk("byte_data", 32'(byte_data), 32'(e));
          end
        end
        if (done) begin
          n_done++;
          if (exp_done == 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_unexpected: got done=1 expected 0");
          end else begin
            exp_done--;
            chk("done_rx_count", 32'(rx_count), 32'(m_cnt));
            chk("done_rx_data0", 32'(rx_data0), 32'(m_rx[0]));
            chk("done_rx_data1", 32'(rx_data1), 32'(m_rx[1]));
            chk("done_rx_data2", 32'(rx_data2), 32'(m_rx[2]));
          end
        end
        if (quiet) begin
          chk("quiet_sda_oe_n", 32'(sda_oe_n), 32'd1);
          chk("quiet_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wq(Q);
    m_scl = 1'b1; wq(2 * Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Master releases SDA for the 9th clock and checks the target's answer mid-high
  task automatic ack_slot(input string name, input bit exp_ack, input bit chk_busy);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    chk(name, 32'(sda_oe_n), 32'(!exp_ack));
    if (chk_busy) chk("busy_in_txn", 32'(busy), 32'd1);
    wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  // One write transaction: START, address byte, n bytes from tx_d, then STOP or nothing (repeated START follows)
  task automatic do_txn(input logic [7:0] ab, input int n, input bit stop_end);
    bit match;
    bit ack;
    i2c_start();
    match = (ab[7:1] == tgt) && !ab[0];
    quiet = !match;
    send_byte(ab);
    ack_slot("addr_ack", match, 1'b0);
    for (int i = 0; i < n; i++) begin
      ack = match && (i < 3);
      if (ack) begin
        exp_q.push_back(tx_d[i]);
        m_rx[i] = tx_d[i];
      end
      send_byte(tx_d[i]);
      ack_slot("data_ack", ack, match);
    end
    if (stop_end) begin
      if (match) begin
        exp_done++;
        m_cnt = (n > 3) ? 2'd3 : 2'(n);
      end
      i2c_stop();
      wq(12);
      quiet = 1'b0;
      chk("done_missing", 32'(exp_done), 32'd0);
      chk("byte_valid_missing", 32'(exp_q.size()), 32'd0);
      chk("busy_after_stop", 32'(busy), 32'd0);
      chk("rx_count", 32'(rx_count), 32'(m_cnt));
      chk("rx_data0", 32'(rx_data0), 32'(m_rx[0]));
      chk("rx_data1", 32'(rx_data1), 32'(m_rx[1]));
      chk("rx_data2", 32'(rx_data2), 32'(m_rx[2]));
    end else begin
      quiet = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sda_oe_n"}, 32'(sda_oe_n), 32'd1);
    chk({tag, "_rx_data0"}, 32'(rx_data0), 32'd0);
    chk({tag, "_rx_data1"}, 32'(rx_data1), 32'd0);
    chk({tag, "_rx_data2"}, 32'(rx_data2), 32'd0);
    chk({tag, "_rx_count"}, 32'(rx_count), 32'd0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nd;
    int n;
    int r;
    bit st;
    bit last_stop;
    logic [7:0] ab;

    reset_n = 1'b0;
    tgt     = 7'h41;
    m_rx    = '{8'h00, 8'h00, 8'h00};
    m_cnt   = 2'd0;
    wq(3);
    chk_reset_outputs("por");
    reset_n = 1'b1;
    wq(8);

    // Full 3-byte write to the matching address
    tx_d[0] = 8'hFF; tx_d[1] = 8'hF1; tx_d[2] = 8'h7E;
    nd = n_done;
    do_txn(8'h82, 3, 1'b1);
    chk("t1_rx_data0", 32'(rx_data0), 32'hFF);
    chk("t1_rx_data1", 32'(rx_data1), 32'hF1);
    chk("t1_rx_data2", 32'(rx_data2), 32'h7E);
    chk("t1_rx_count", 32'(rx_count), 32'd3);
    chk("t1_done_count", 32'(n_done - nd), 32'd1);

    // Wrong address: never driven, registers untouched
    tx_d[0] = 8'h55; tx_d[1] = 8'hAA;
    do_txn(8'h84, 2, 1'b1);
    chk("t2_rx_data0", 32'(rx_data0), 32'hFF);

    // Matching address with read bit: NACK, nothing captured
    nd = n_done;
    do_txn(8'h83, 1, 1'b1);
    chk("t3_done_count", 32'(n_done - nd), 32'd0);

    // Four bytes: the fourth is NACKed
    tx_d[0] = 8'h11; tx_d[1] = 8'h22; tx_d[2] = 8'h33; tx_d[3] = 8'h44;
    do_txn(8'h82, 4, 1'b1);
    chk("t4_rx_count", 32'(rx_count), 32'd3);
    chk("t4_rx_data2", 32'(rx_data2), 32'h33);

    // One byte, repeated START, two bytes, STOP
    nd = n_done;
    tx_d[0] = 8'hA5;
    do_txn(8'h82, 1, 1'b0);
    tx_d[0] = 8'h5A; tx_d[1] = 8'hC3;
    do_txn(8'h82, 2, 1'b1);
    chk("t5_done_count", 32'(n_done - nd), 32'd1);
    chk("t5_rx_count", 32'(rx_count), 32'd2);
    chk("t5_rx_data0", 32'(rx_data0), 32'h5A);
    chk("t5_rx_data1", 32'(rx_data1), 32'hC3);

    // Reset in the middle of the second data byte
    i2c_start();
    send_byte(8'h82);
    ack_slot("rst_addr_ack", 1'b1, 1'b0);
    exp_q.push_back(8'h12);
    m_rx[0] = 8'h12;
    send_byte(8'h12);
    ack_slot("rst_d0_ack", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    m_rx  = '{8'h00, 8'h00, 8'h00};
    m_cnt = 2'd0;
    exp_q.delete();
    m_sda = 1'b1;
    m_scl = 1'b1;
    wq(5);
    reset_n = 1'b1;
    wq(5);
    // SCL keeps toggling without a START: the target must stay idle
    quiet = 1'b1;
    m_scl = 1'b0; wq(Q);
    for (int i = 0; i < 18; i++) send_bit(1'($urandom_range(0, 1)));
    i2c_stop();
    wq(10);
    quiet = 1'b0;
    tx_d[0] = 8'h3C;
    do_txn(8'h82, 1, 1'b1);
    chk("t6_rx_count", 32'(rx_count), 32'd1);
    chk("t6_rx_data0", 32'(rx_data0), 32'h3C);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // 2-clk SDA low pulse with SCL high must not be taken as START
    m_sda = 1'b0; wq(2);
    m_sda = 1'b1; wq(20);
    quiet = 1'b1;
    m_scl = 1'b0; wq(Q);
    send_byte({tgt, 1'b0});
    ack_slot("glitch_no_ack", 1'b0, 1'b0);
    i2c_stop();
    wq(10);
    quiet = 1'b0;
`endif

    // Randomized transactions
    last_stop = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (last_stop) tgt = 7'($urandom_range(0, 127));
      r = $urandom_range(0, 99);
      if (r < 60)      ab = {tgt, 1'b0};
      else if (r < 75) ab = {tgt, 1'b1};
      else             ab = 8'($urandom);
      n = $urandom_range(0, 5);
      for (int i = 0; i < 6; i++) tx_d[i] = 8'($urandom);
      st = (t == 19) || ($urandom_range(0, 4) != 0);
      do_txn(ab, n, st);
      last_stop = st;
    end

    wq(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Write-only I2C target (slave) receiver; the far end of the team's `i2c_basic` master write path.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs and captures up to 3 write data bytes, then signals completion on STOP.
- Used on-chip as a loopback partner for the master and as a control-register ingress port.

Parameters:
- MAX_BYTES, 3: data bytes accepted per transaction (fixed at 3; the counter and outputs are sized for it).
- SYNC_STAGES, 2: synchronizer flops on each of the SCL and SDA inputs (minimum 2).

Ports:
- clk  in  1  system clock; must be ≥8x the SCL rate.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  7  target address to match; must be held static during a transaction.
- scl  in  1  I2C clock from the bus (asynchronous).
- sda_in  in  1  I2C data from the bus (asynchronous).
- sda_oe_n  out  1  open-drain SDA pull-down enable; 0 drives SDA low.
- rx_data0  out  8  first received data byte.
- rx_data1  out  8  second received data byte.
- rx_data2  out  8  third received data byte.
- rx_count  out  2  number of data bytes ACKed in the last completed transaction.
- byte_valid  out  1  one-cycle strobe per ACKed data byte.
- byte_data  out  8  the byte accompanying byte_valid.
- busy  out  1  high while the target is addressed (from the ACKed address through STOP).
- done  out  1  one-cycle pulse on STOP ending a matched transaction.

Behaviour:
- Reset values: sda_oe_n=1; rx_data0..2=0; byte_data=0; rx_count=0; byte_valid=0; busy=0; done=0; state IDLE.
- Input path: SCL and SDA each pass SYNC_STAGES flops, then a 1-flop edge detector. Bus-to-internal event latency is SYNC_STAGES+1 clk.
- START: synchronized SDA falls while synchronized SCL is high.
- STOP: synchronized SDA rises while synchronized SCL is high.
- Bit sampling: SDA is sampled on SCL rising edges, MSB first. A 3-bit bit counter and an 8-bit shift register hold the byte in progress.
- States:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift 8 bits. On the 8th SCL fall:
    - shift[7:1]==addr and shift[0]==0 → ADDR_ACK, with sda_oe_n=0 asserted that cycle.
    - anything else, including R/W=1 → WAIT_STOP, sda_oe_n stays 1 (NACK).
  - ADDR_ACK: hold sda_oe_n=0 until the next SCL fall, then release it. Set busy=1, clear the internal byte index, go to DATA.
  - DATA: shift 8 bits. On the 8th SCL fall:
    - byte index < MAX_BYTES → store into rx_data[index], drive byte_valid=1 and byte_data for one clk, set sda_oe_n=0, go to DATA_ACK.
    - otherwise → NACK and go to WAIT_STOP; the byte is not stored and no byte_valid is issued.
  - DATA_ACK: hold sda_oe_n=0 until the next SCL fall, then release it, increment the index, go to DATA.
  - WAIT_STOP: ignore bus traffic except START/STOP.
- STOP handling, in any state:
  - If busy: rx_count=index, done=1 for one clk, busy=0.
  - Go to IDLE and release sda_oe_n.
- Repeated START in any non-IDLE state:
  - Abort to ADDR: index cleared, busy=0, sda_oe_n=1, no done.
  - rx_data and rx_count keep their prior values.
- Same-cycle START and STOP detection cannot occur (single SDA edge). If a STOP and an SCL fall are seen in the same clk, STOP wins.
- rx_data registers are overwritten only by ACKed bytes. Unwritten registers keep stale values; rx_count tells the consumer how many are valid.
- Asserting reset_n mid-transaction:
  - All outputs return to reset values immediately and SDA is released.
  - After deassertion, the block stays in IDLE until a fresh START, even if SCL is toggling.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: after the synchronizers, each of SCL and SDA passes a 3-sample stability filter. The filtered output changes only after 3 consecutive equal samples, so pulses of 2 clk or shorter are rejected. Event latency becomes SYNC_STAGES+4 clk.
- Undefined: no filter; latency SYNC_STAGES+1 clk.

Test Plan:
- Master writes addr=0x41, W, data FF,F1,7E, then STOP, with target addr=0x41 → ACK on all 4 bytes; byte_valid ×3 with byte_data FF/F1/7E; done=1 once; rx_data0..2=FF/F1/7E; rx_count=3.
- Master writes to addr 0x42 while target addr=0x41 → sda_oe_n stays 1 throughout; busy=0; done=0; rx_data unchanged.
- Master sends addr 0x41 with R/W=1 → NACK; no byte_valid; no done.
- Master writes 4 bytes 11,22,33,44 → the first 3 are ACKed, the 4th is NACKed (sda_oe_n=1 in its ACK slot); rx_count=3; rx_data2=33.
- Master writes 1 byte A5, then repeated START, then writes 2 bytes 5A,C3, then STOP → exactly one done; rx_count=2; rx_data0=5A; rx_data1=C3.
- reset_n pulled low during the second data byte → sda_oe_n=1 and all outputs 0 within the same clk. A following clean 1-byte write of 0x3C then completes with rx_count=1 and rx_data0=3C.
- With I2C_TARGET_GLITCH_FILTER_EN defined, a 2-clk SDA low pulse while SCL is high in IDLE → no START detected and the state stays IDLE.
